// File: rtl/smi_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : smi_pkg                                                          |
// | Desc     : Shared SMI frame constants, final-flit test and FSM state enums. |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package smi_pkg;

  localparam logic [7:0] WRITE_REQ_ID    = 8'h01;
  localparam logic [7:0] READ_REQ_ID     = 8'h02;
  localparam logic [7:0] ID_BYTE_MASK    = 8'hFF;
  localparam int         TAG_BYTE_OFFSET = 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FWD  = 1'b1
  } reqState_t;

  typedef enum logic [1:0] {
    RIDLE = 2'd0,
    RFWD  = 2'd1,
    RDROP = 2'd2
  } respState_t;

  function automatic logic isFinalFlit(input logic [7:0] eofc);
    return |eofc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/smi_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : smi_rr_arbiter                                                   |
// | Desc     : Combinational round-robin picker: first eligible after lastGrant.|
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module smi_rr_arbiter #(
  parameter int NumPorts      = 4,
  parameter int PortIndexSize = 2
) (
  input  logic [NumPorts-1:0]      eligible,
  input  logic [PortIndexSize-1:0] lastGrant,
  output logic [PortIndexSize-1:0] grant,
  output logic                     valid
);

  // Lowest eligible index above lastGrant wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (eligible[i] && (PortIndexSize'(i) <= lastGrant)) begin
        grant = PortIndexSize'(i);
        valid = 1'b1;
      end
    end
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (eligible[i] && (PortIndexSize'(i) > lastGrant)) begin
        grant = PortIndexSize'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/smi_multi_port_mux.sv
// +----------------------------------------------------------------------------+
// | Module   : smi_multi_port_mux                                               |
// | Desc     : N-port SMI frame mux with tag-routed responses and credits.      |
// |            SMI_MULTI_PORT_ERR_COUNT_EN adds the misrouteCount output.       |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module smi_multi_port_mux
  import smi_pkg::*;
#(
  parameter int NumPorts       = 4,
  parameter int PortIndexSize  = 2,
  parameter int DataIndexSize  = 4,
  parameter int MaxOutstanding = 8
) (
  input  logic                                        clk,
  input  logic                                        arstN,
`ifdef SMI_MULTI_PORT_ERR_COUNT_EN
  output logic [15:0]                                 misrouteCount,
`endif
  input  logic [NumPorts-1:0]                         upReqReady,
  input  logic [8*NumPorts-1:0]                       upReqEofc,
  input  logic [(1<<DataIndexSize)*8*NumPorts-1:0]    upReqData,
  output logic [NumPorts-1:0]                         upReqStop,
  output logic [NumPorts-1:0]                         upRespReady,
  output logic [8*NumPorts-1:0]                       upRespEofc,
  output logic [(1<<DataIndexSize)*8*NumPorts-1:0]    upRespData,
  input  logic [NumPorts-1:0]                         upRespStop,
  output logic                                        dnReqReady,
  output logic [7:0]                                  dnReqEofc,
  output logic [(1<<DataIndexSize)*8-1:0]             dnReqData,
  input  logic                                        dnReqStop,
  input  logic                                        dnRespReady,
  input  logic [7:0]                                  dnRespEofc,
  input  logic [(1<<DataIndexSize)*8-1:0]             dnRespData,
  output logic                                        dnRespStop
);

  localparam int         FlitBits  = (1 << DataIndexSize) * 8;
  localparam int         TagLsb    = TAG_BYTE_OFFSET * 8;
  localparam logic [7:0] MaxCredit = 8'(MaxOutstanding);

  reqState_t                r_reqState;
  logic [PortIndexSize-1:0] r_grant;
  logic [PortIndexSize-1:0] r_lastGrant;
  logic                     r_reqHeader;
  logic [NumPorts-1:0]      w_eligible;
  logic [PortIndexSize-1:0] w_arbGrant;
  logic                     w_arbValid;
  logic                     w_reqXfer;
  logic                     w_reqFinal;

  respState_t               r_respState;
  logic [PortIndexSize-1:0] r_route;
  logic                     r_respHeader;
  logic [PortIndexSize-1:0] w_respTag;
  logic                     w_respBadTag;
  logic                     w_routeStop;
  logic [FlitBits-1:0]      w_respFlit;
  logic                     w_respXfer;
  logic                     w_respFinal;
  logic                     w_respDeliver;

  smi_rr_arbiter #(
    .NumPorts      (NumPorts),
    .PortIndexSize (PortIndexSize)
  ) u_arbiter (
    .eligible  (w_eligible),
    .lastGrant (r_lastGrant),
    .grant     (w_arbGrant),
    .valid     (w_arbValid)
  );

  // Request pass-through; the header tag field is rewritten with the grant index.
  always_comb begin
    dnReqReady = 1'b0;
    dnReqEofc  = '0;
    dnReqData  = '0;
    for (int i = 0; i < NumPorts; i++) begin
      upReqStop[i] = 1'b1;
      if ((r_reqState == FWD) && (PortIndexSize'(i) == r_grant)) begin
        upReqStop[i] = dnReqStop;
        dnReqReady   = upReqReady[i];
        dnReqEofc    = upReqEofc[i*8 +: 8];
        dnReqData    = upReqData[i*FlitBits +: FlitBits];
      end
    end
    if (r_reqHeader) begin
      dnReqData[TagLsb +: PortIndexSize] = r_grant;
    end
  end

  assign w_reqXfer  = dnReqReady && !dnReqStop;
  assign w_reqFinal = w_reqXfer && isFinalFlit(dnReqEofc);

  always_ff @(posedge clk or negedge arstN) begin
    if (!arstN) begin
      r_reqState  <= IDLE;
      r_grant     <= '0;
      r_lastGrant <= PortIndexSize'(NumPorts - 1);
      r_reqHeader <= 1'b0;
    end else begin
      case (r_reqState)
        IDLE: begin
          if (w_arbValid) begin
            r_grant     <= w_arbGrant;
            r_reqHeader <= 1'b1;
            r_reqState  <= FWD;
          end
        end
        FWD: begin
          if (w_reqXfer) begin
            r_reqHeader <= 1'b0;
          end
          if (w_reqFinal) begin
            r_lastGrant <= r_grant;
            r_reqState  <= IDLE;
          end
        end
        default: r_reqState <= IDLE;
      endcase
    end
  end

  // Per-port outstanding-frame credits gate eligibility.
  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_credit
    logic [7:0] r_credit;
    logic       w_inc;
    logic       w_dec;

    assign w_inc         = w_reqFinal && (r_grant == PortIndexSize'(gi));
    assign w_dec         = w_respDeliver && (r_route == PortIndexSize'(gi));
    assign w_eligible[gi] = upReqReady[gi] && (r_credit < MaxCredit);

    always_ff @(posedge clk or negedge arstN) begin
      if (!arstN) begin
        r_credit <= '0;
      end else if (w_inc && !w_dec && (r_credit != MaxCredit)) begin
        r_credit <= r_credit + 8'd1;
      end else if (w_dec && !w_inc && (r_credit != 8'd0)) begin
        r_credit <= r_credit - 8'd1;
      end
    end
  end

  assign w_respTag    = dnRespData[TagLsb +: PortIndexSize];
  assign w_respBadTag = (int'(w_respTag) >= NumPorts);

  always_comb begin
    w_respFlit = dnRespData;
    if (r_respHeader) begin
      w_respFlit[TagLsb +: PortIndexSize] = '0;
    end
  end

  always_comb begin
    upRespReady = '0;
    upRespEofc  = '0;
    upRespData  = '0;
    w_routeStop = 1'b1;
    for (int i = 0; i < NumPorts; i++) begin
      if (PortIndexSize'(i) == r_route) begin
        w_routeStop = upRespStop[i];
        if (r_respState == RFWD) begin
          upRespReady[i]                     = dnRespReady;
          upRespEofc[i*8 +: 8]               = dnRespEofc;
          upRespData[i*FlitBits +: FlitBits] = w_respFlit;
        end
      end
    end
  end

  always_comb begin
    case (r_respState)
      RFWD:    dnRespStop = w_routeStop;
      RDROP:   dnRespStop = 1'b0;
      default: dnRespStop = 1'b1;
    endcase
  end

  assign w_respXfer    = dnRespReady && !dnRespStop;
  assign w_respFinal   = w_respXfer && isFinalFlit(dnRespEofc);
  assign w_respDeliver = (r_respState == RFWD) && w_respFinal;

  // The header waits one cycle in RIDLE while its tag is latched.
  always_ff @(posedge clk or negedge arstN) begin
    if (!arstN) begin
      r_respState  <= RIDLE;
      r_route      <= '0;
      r_respHeader <= 1'b0;
    end else begin
      case (r_respState)
        RIDLE: begin
          if (dnRespReady) begin
            r_route      <= w_respTag;
            r_respHeader <= 1'b1;
            r_respState  <= w_respBadTag ? RDROP : RFWD;
          end
        end
        RFWD: begin
          if (w_respXfer) begin
            r_respHeader <= 1'b0;
          end
          if (w_respFinal) begin
            r_respState <= RIDLE;
          end
        end
        RDROP: begin
          if (w_respFinal) begin
            r_respState <= RIDLE;
          end
        end
        default: r_respState <= RIDLE;
      endcase
    end
  end

`ifdef SMI_MULTI_PORT_ERR_COUNT_EN
  always_ff @(posedge clk or negedge arstN) begin
    if (!arstN) begin
      misrouteCount <= '0;
    end else if ((r_respState == RIDLE) && dnRespReady && w_respBadTag &&
                 (misrouteCount != 16'hFFFF)) begin
      misrouteCount <= misrouteCount + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_smi_multi_port_mux.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_smi_multi_port_mux                                            |
// | Desc     : Directed self-checking bench for smi_multi_port_mux (5 ports,    |
// |            32-bit flits, 2 credits per port).                               |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_smi_multi_port_mux;

  localparam int NP = 5;
  localparam int FB = 32;

  logic              clk = 1'b0;
  logic              arstN;
  logic [NP-1:0]     upReqReady;
  logic [8*NP-1:0]   upReqEofc;
  logic [FB*NP-1:0]  upReqData;
  logic [NP-1:0]     upReqStop;
  logic [NP-1:0]     upRespReady;
  logic [8*NP-1:0]   upRespEofc;
  logic [FB*NP-1:0]  upRespData;
  logic [NP-1:0]     upRespStop;
  logic              dnReqReady;
  logic [7:0]        dnReqEofc;
  logic [FB-1:0]     dnReqData;
  logic              dnReqStop;
  logic              dnRespReady;
  logic [7:0]        dnRespEofc;
  logic [FB-1:0]     dnRespData;
  logic              dnRespStop;
`ifdef SMI_MULTI_PORT_ERR_COUNT_EN
  logic [15:0]       misrouteCount;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] expRrData [6] = '{32'h0000_00A0, 32'h0000_01A1, 32'h0000_02A2,
                                 32'h0000_03A3, 32'h0000_04A4, 32'h0000_00A0};
  logic [4:0]  expRrStop [6] = '{5'b11110, 5'b11101, 5'b11011,
                                 5'b10111, 5'b01111, 5'b11110};

  always #5 clk = ~clk;

  smi_multi_port_mux #(
    .NumPorts       (NP),
    .PortIndexSize  (3),
    .DataIndexSize  (2),
    .MaxOutstanding (2)
  ) dut (
    .clk           (clk),
    .arstN         (arstN),
`ifdef SMI_MULTI_PORT_ERR_COUNT_EN
    .misrouteCount (misrouteCount),
`endif
    .upReqReady    (upReqReady),
    .upReqEofc     (upReqEofc),
    .upReqData     (upReqData),
    .upReqStop     (upReqStop),
    .upRespReady   (upRespReady),
    .upRespEofc    (upRespEofc),
    .upRespData    (upRespData),
    .upRespStop    (upRespStop),
    .dnReqReady    (dnReqReady),
    .dnReqEofc     (dnReqEofc),
    .dnReqData     (dnReqData),
    .dnReqStop     (dnReqStop),
    .dnRespReady   (dnRespReady),
    .dnRespEofc    (dnRespEofc),
    .dnRespData    (dnRespData),
    .dnRespStop    (dnRespStop)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int p, input logic rdy, input logic [7:0] eofc, input logic [31:0] d);
    upReqReady[p]       = rdy;
    upReqEofc[p*8 +: 8] = eofc;
    upReqData[p*FB +: FB] = d;
  endtask

  task automatic setResp(input logic rdy, input logic [7:0] eofc, input logic [31:0] d);
    dnRespReady = rdy;
    dnRespEofc  = eofc;
    dnRespData  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arstN      = 1'b0;
    upReqReady = '0;
    upReqEofc  = '0;
    upReqData  = '0;
    upRespStop = '0;
    dnReqStop  = 1'b0;
    setResp(1'b0, 8'h00, 32'h0);
    #3;
    check("rst_upReqStop", upReqStop, 5'h1F);
    check("rst_dnReqReady", dnReqReady, 1'b0);
    check("rst_upRespReady", upRespReady, 5'h00);
    check("rst_dnRespStop", dnRespStop, 1'b1);
`ifdef SMI_MULTI_PORT_ERR_COUNT_EN
    check("rst_misroute", misrouteCount, 16'h0);
`endif
    @(negedge clk);
    arstN = 1'b1;

    // Round robin over all ports with single-flit frames
    @(negedge clk);
    for (int p = 0; p < NP; p++) setReq(p, 1'b1, 8'h01, 32'h0000_00A0 + 32'(p));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      check("rr_ready", dnReqReady, 1'b1);
      check("rr_data", dnReqData, expRrData[k]);
      check("rr_stop", upReqStop, expRrStop[k]);
      @(negedge clk); #1;
      check("rr_bubble", dnReqReady, 1'b0);
    end
    upReqReady = '0;

    // Port 2 three-flit write frame
    @(negedge clk);
    setReq(2, 1'b1, 8'h00, 32'h1234_0001); #1;
    check("a_idle_ready", dnReqReady, 1'b0);
    check("a_idle_stop", upReqStop, 5'h1F);
    @(negedge clk); #1;
    check("a_hdr_data", dnReqData, 32'h1234_0201);
    check("a_hdr_stop", upReqStop, 5'b11011);
    check("a_hdr_eofc", dnReqEofc, 8'h00);
    @(negedge clk);
    setReq(2, 1'b1, 8'h00, 32'h5555_6666); #1;
    check("a_body_data", dnReqData, 32'h5555_6666);
    @(negedge clk);
    setReq(2, 1'b1, 8'h01, 32'h7777_8888); #1;
    check("a_last_data", dnReqData, 32'h7777_8888);
    check("a_last_eofc", dnReqEofc, 8'h01);
    @(negedge clk);
    setReq(2, 1'b0, 8'h00, 32'h0); #1;
    check("a_done_ready", dnReqReady, 1'b0);
    check("a_done_stop", upReqStop, 5'h1F);

    // Port 1 reaches its credit limit, then a tag-1 response frees one
    @(negedge clk);
    setReq(1, 1'b1, 8'h01, 32'h0000_0511);
    @(negedge clk); #1;
    check("c_f1_data", dnReqData, 32'h0000_0111);
    @(negedge clk); #1;
    check("c_stall_ready", dnReqReady, 1'b0);
    check("c_stall_stop", upReqStop[1], 1'b1);
    @(negedge clk); #1;
    check("c_stall2_ready", dnReqReady, 1'b0);
    setResp(1'b1, 8'h01, 32'hCAFE_0102); #1;
    check("c_ridle_stop", dnRespStop, 1'b1);
    check("c_ridle_ready", upRespReady, 5'h00);
    @(negedge clk); #1;
    check("c_resp_ready", upRespReady, 5'b00010);
    check("c_resp_data", upRespData[1*FB +: FB], 32'hCAFE_0002);
    check("c_resp_eofc", upRespEofc[1*8 +: 8], 8'h01);
    check("c_resp_stop", dnRespStop, 1'b0);
    check("c_still_stalled", dnReqReady, 1'b0);
    @(negedge clk);
    setResp(1'b0, 8'h00, 32'h0); #1;
    check("c_resp_done", upRespReady, 5'h00);
    check("c_arb_pending", dnReqReady, 1'b0);
    @(negedge clk); #1;
    check("c_regrant_ready", dnReqReady, 1'b1);
    check("c_regrant_data", dnReqData, 32'h0000_0111);
    @(negedge clk);
    setReq(1, 1'b0, 8'h00, 32'h0);

    // Response to port 3 with port 3 backpressuring for five cycles
    @(negedge clk);
    setResp(1'b1, 8'h00, 32'hBEEF_0302);
    upRespStop = 5'b01000; #1;
    check("d_ridle_stop", dnRespStop, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("d_held_stop", dnRespStop, 1'b1);
      check("d_held_ready", upRespReady, 5'b01000);
    end
    upRespStop = '0; #1;
    check("d_hdr_stop", dnRespStop, 1'b0);
    check("d_hdr_data", upRespData[3*FB +: FB], 32'hBEEF_0002);
    check("d_other_data", upRespData[0*FB +: FB], 32'h0);
    @(negedge clk);
    setResp(1'b1, 8'h02, 32'h1357_0F9B); #1;
    check("d_last_data", upRespData[3*FB +: FB], 32'h1357_0F9B);
    check("d_last_eofc", upRespEofc[3*8 +: 8], 8'h02);
    check("d_last_ready", upRespReady, 5'b01000);
    @(negedge clk);
    setResp(1'b0, 8'h00, 32'h0); #1;
    check("d_done_stop", dnRespStop, 1'b1);
    check("d_done_ready", upRespReady, 5'h00);

    // Out-of-range tag 7 is dropped
    @(negedge clk);
    setResp(1'b1, 8'h00, 32'h0000_0702); #1;
    check("e_ridle_stop", dnRespStop, 1'b1);
    @(negedge clk); #1;
    check("e_drop_stop", dnRespStop, 1'b0);
    check("e_drop_ready", upRespReady, 5'h00);
    @(negedge clk);
    setResp(1'b1, 8'h01, 32'h0000_1111); #1;
    check("e_last_ready", upRespReady, 5'h00);
    check("e_last_stop", dnRespStop, 1'b0);
    @(negedge clk);
    setResp(1'b0, 8'h00, 32'h0); #1;
    check("e_done_stop", dnRespStop, 1'b1);
`ifdef SMI_MULTI_PORT_ERR_COUNT_EN
    check("e_misroute", misrouteCount, 16'h1);
`endif

    // Free one port-0 credit
    @(negedge clk);
    setResp(1'b1, 8'h01, 32'h0000_0002);
    @(negedge clk); #1;
    check("f_resp0_ready", upRespReady, 5'b00001);
    @(negedge clk);
    setResp(1'b0, 8'h00, 32'h0);

    // Reset in the middle of a port-0 frame
    setReq(0, 1'b1, 8'h00, 32'h0000_00C0);
    setReq(2, 1'b1, 8'h01, 32'h0000_00C2);
    @(negedge clk); #1;
    check("f_fwd_ready", dnReqReady, 1'b1);
    check("f_fwd_stop", upReqStop, 5'b11110);
    @(negedge clk); #2;
    arstN = 1'b0; #1;
    check("f_rst_dnReqReady", dnReqReady, 1'b0);
    check("f_rst_upReqStop", upReqStop, 5'h1F);
    check("f_rst_upRespReady", upRespReady, 5'h00);
    check("f_rst_dnRespStop", dnRespStop, 1'b1);
    @(negedge clk);
    arstN = 1'b1;
    @(negedge clk); #1;
    check("f_regrant_data", dnReqData, 32'h0000_00C0);
    check("f_regrant_stop", upReqStop, 5'b11110);
    setReq(0, 1'b1, 8'h01, 32'h0000_00C0);
    @(negedge clk);
    setReq(0, 1'b0, 8'h00, 32'h0); #1;
    check("f_bubble", dnReqReady, 1'b0);
    @(negedge clk); #1;
    check("f_port2_ready", dnReqReady, 1'b1);
    check("f_port2_data", dnReqData, 32'h0000_02C2);
    @(negedge clk);
    setReq(2, 1'b0, 8'h00, 32'h0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/smi_multi_port_mux.md
# smi_multi_port_mux

N-port SMI frame multiplexer placed upstream of the SMI-to-AXI bus adaptor, so several kernel SMI ports share one AXI memory interface. Request frames from NumPorts upstream ports are arbitrated round-robin at frame granularity and tagged with their source port. Response frames are steered back to the originating port by that tag. Per-port credit counters bound the number of outstanding transactions.

## Interface
- NumPorts, 4: upstream SMI port count, 2..16.
- PortIndexSize, 2: bits of port index, ceil(log2(NumPorts)).
- DataIndexSize, 4: flit width is 1<<DataIndexSize bytes.
- MaxOutstanding, 8: per-port in-flight frame limit, 1..255.
- clk  in  1  clock.
- arstN  in  1  reset, asynchronous, active-low.
- upReqReady  in  NumPorts  per-port request flit valid.
- upReqEofc  in  8*NumPorts  per-port end-of-frame control.
- upReqData  in  FlitWidth*8*NumPorts  per-port request data.
- upReqStop  out  NumPorts  per-port backpressure.
- upRespReady  out  NumPorts  per-port response valid.
- upRespEofc  out  8*NumPorts  per-port response end-of-frame control.
- upRespData  out  FlitWidth*8*NumPorts  per-port response data.
- upRespStop  in  NumPorts  per-port response backpressure.
- dnReqReady/dnReqEofc/dnReqData  out  1/8/FlitWidth*8  merged request stream.
- dnReqStop  in  1  merged request backpressure.
- dnRespReady/dnRespEofc/dnRespData  in  1/8/FlitWidth*8  merged response stream.
- dnRespStop  out  1  merged response backpressure.
- Port i occupies slice i of each packed vector.

## Operation
- Flit transfer: Ready=1 and Stop=0 in the same cycle. Eofc=0 marks a non-final flit; Eofc≠0 marks a final flit.
- Header flit is the first flit of a frame. Byte 0 is the type ID. Byte 1, bits [PortIndexSize-1:0], hold the port tag.
- Request FSM:
  - IDLE: eligible ports have Ready=1 and credit<MaxOutstanding. Pick the first eligible port after lastGrant, wrapping. Register grant and go to FWD. No eligible port: stay in IDLE.
  - FWD: pass the granted port's flits through combinationally. The tag field of the header flit is overwritten with the grant index. Other ports see Stop=1.
  - FWD to IDLE on final-flit transfer. lastGrant updates at the same time.
- Credit counters: increment on request final-flit transfer and decrement on response final-flit delivery. Both in the same cycle leaves the count unchanged. The counter never exceeds MaxOutstanding and never goes below 0.
- Response FSM:
  - RIDLE: dnRespStop=1. When dnRespReady=1, latch the header tag into route.
    - Tag < NumPorts: go to RFWD.
    - Otherwise: go to RDROP.
  - RFWD: pass flits to port route. The header tag field is cleared to 0. dnRespStop = upRespStop[route].
  - RDROP: dnRespStop=0. Discard flits until the final flit.
  - RFWD/RDROP to RIDLE on final-flit transfer.

## Timing
- Reset values:
  - upReqStop all 1s; dnReqReady 0; upRespReady 0; dnRespStop 1.
  - Both FSMs in idle; credits 0; lastGrant NumPorts-1, so port 0 has first priority.
- Reset mid-frame abandons the frame. Nothing is replayed.
- Request path:
  - One bubble cycle between frames (arbitration cycle). Back-to-back single-flit frames run at 50% throughput.
  - Within a frame, throughput is 1 flit/cycle with zero added latency.
- Response path: the header is held 1 cycle in RIDLE, then forwarded at 1 flit/cycle.
- Single-flit frame in FWD: the credit update and the return to IDLE happen on the same edge.
- A port at credit=MaxOutstanding is skipped. It becomes eligible the cycle after its response final flit is delivered.

## Configuration
- SMI_MULTI_PORT_ERR_COUNT_EN defined:
  - Adds output misrouteCount[15:0], reset 0.
  - Increments once per frame entering RDROP and saturates at 0xFFFF.
- Undefined: the port is absent and RDROP frames are discarded silently.

## Structure
- Shared package smi_pkg holds:
  - WRITE_REQ_ID (0x01), READ_REQ_ID (0x02), ID_BYTE_MASK (0xFF);
  - header tag byte offset (1);
  - the Eofc final-flit test;
  - the FSM state enums.
- Sub-module smi_rr_arbiter: combinational round-robin picker with inputs eligible[NumPorts] and lastGrant, and outputs grant index and valid.

## Test plan
- Port 2 sends a 3-flit write frame with byte1=0x00 -> dnReq carries 3 flits with header byte1=0x02; port 2 credit reads 1.
- All 4 ports request single-flit frames continuously -> grant order 0,1,2,3,0; one bubble between frames.
- MaxOutstanding=2; port 1 sends 3 frames with no responses -> third frame stalled (upReqStop[1]=1) until a response with tag 1 completes.
- Response header byte1=0x03, 2 flits, upRespStop[3] held 1 for 5 cycles -> dnRespStop=1 for those cycles; port 3 receives 2 flits with byte1=0x00.
- NumPorts=3, response tag 3 -> frame dropped, no upRespReady asserted; misrouteCount=1 when SMI_MULTI_PORT_ERR_COUNT_EN is defined.
- arstN asserted mid-frame on port 0 -> all outputs return to reset values immediately; credits 0; next grant goes to port 0.
